// File: rtl/cicc_cfg_pkg.sv
// Shared constants, state encoding and write-port payload for the CICC coefficient loader.
// CICC_COEF_DBUF_EN selects the ping-pong (double-bank) RAM layout.
package cicc_cfg_pkg;

  localparam int unsigned CONFIG_WIDTH         = 32;
  localparam int unsigned CICC_COEFF_WIDTH     = 24;
  localparam int unsigned CICC_SCALE_WIDTH     = 16;
  localparam int unsigned FILTER_ORDER         = 256;
  localparam int unsigned COEF_NUM             = FILTER_ORDER + 1;
  localparam int unsigned CICC_CONFIG_DATA_NUM = COEF_NUM + 2;
  localparam int unsigned ADDR_WIDTH           = 9;
  localparam int unsigned CNT_WIDTH            = $clog2(CICC_CONFIG_DATA_NUM);

  localparam int unsigned IDX_SCALE = COEF_NUM;
  localparam int unsigned IDX_SYM   = COEF_NUM + 1;

  // Bank select lives in the RAM address MSB when double-buffered.
`ifdef CICC_COEF_DBUF_EN
  localparam int unsigned RAM_AW = ADDR_WIDTH + 1;
`else
  localparam int unsigned RAM_AW = ADDR_WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SWAP = 2'd2
  } cicc_state_e;

  typedef struct packed {
    logic                        en;
    logic [RAM_AW-1:0]           addr;
    logic [CICC_COEFF_WIDTH-1:0] data;
  } coef_wr_t;

  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    return a < ADDR_WIDTH'(COEF_NUM);
  endfunction

endpackage

// File: rtl/cicc_coef_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port.
// Read data is cleared when the read is not enabled (out-of-range addresses).
module cicc_coef_ram
  import cicc_cfg_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  coef_wr_t                    wr_i,
  input  logic                        rd_en_i,
  input  logic [RAM_AW-1:0]           rd_addr_i,
  output logic [CICC_COEFF_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = 1 << RAM_AW;

  logic [CICC_COEFF_WIDTH-1:0] mem_q [DEPTH];
  logic [CICC_COEFF_WIDTH-1:0] rd_data_q;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_i.en) begin
      mem_q[wr_i.addr] <= wr_i.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cicc_coef_loader.sv
// Loads the CICC configuration burst into a shadow coefficient bank and swaps it in atomically.
// CICC_COEF_DBUF_EN: ping-pong banks; undefined: single bank written in place.
module cicc_coef_loader
  import cicc_cfg_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        isConfig,
  input  logic [CONFIG_WIDTH-1:0]     Data_Config_In,
  output logic                        isConfigACK,
  output logic                        isConfigDone,
  input  logic [ADDR_WIDTH-1:0]       Coef_Rd_Addr,
  output logic [CICC_COEFF_WIDTH-1:0] Coef_Rd_Data,
  output logic [CICC_SCALE_WIDTH-1:0] Coef_ScalVal,
  output logic                        isCoefSym,
  output logic                        isCoefValid
);

  cicc_state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        ack_q, ack_d;
  logic                        done_q, done_d;
  logic [CICC_SCALE_WIDTH-1:0] scal_q, scal_d;
  logic [CICC_SCALE_WIDTH-1:0] shd_scal_q, shd_scal_d;
  logic                        sym_q, sym_d;
  logic                        shd_sym_q, shd_sym_d;
  logic                        valid_q, valid_d;
  coef_wr_t                    wr_c;
  logic [RAM_AW-1:0]           rd_addr_c;
  logic                        unused_cfg_bits;

  assign unused_cfg_bits = ^Data_Config_In[CONFIG_WIDTH-1:CICC_COEFF_WIDTH];

`ifdef CICC_COEF_DBUF_EN
  logic bank_sel_q, bank_sel_d;
  // Writes target the idle bank; reads always come from the active one.
  assign rd_addr_c = {bank_sel_q, Coef_Rd_Addr};
`else
  assign rd_addr_c = Coef_Rd_Addr;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      scal_q     <= '0;
      shd_scal_q <= '0;
      sym_q      <= 1'b0;
      shd_sym_q  <= 1'b0;
      valid_q    <= 1'b0;
`ifdef CICC_COEF_DBUF_EN
      bank_sel_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      scal_q     <= scal_d;
      shd_scal_q <= shd_scal_d;
      sym_q      <= sym_d;
      shd_sym_q  <= shd_sym_d;
      valid_q    <= valid_d;
`ifdef CICC_COEF_DBUF_EN
      bank_sel_q <= bank_sel_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    done_d     = 1'b0;
    scal_d     = scal_q;
    shd_scal_d = shd_scal_q;
    sym_d      = sym_q;
    shd_sym_d  = shd_sym_q;
    valid_d    = valid_q;
    wr_c.en    = 1'b0;
    wr_c.data  = Data_Config_In[CICC_COEFF_WIDTH-1:0];
`ifdef CICC_COEF_DBUF_EN
    bank_sel_d = bank_sel_q;
    wr_c.addr  = {~bank_sel_q, ADDR_WIDTH'(cnt_q)};
`else
    wr_c.addr  = ADDR_WIDTH'(cnt_q);
`endif

    case (state_q)
      IDLE: begin
        if (isConfig) begin
          state_d = LOAD;
          cnt_d   = '0;
          ack_d   = 1'b1;
`ifndef CICC_COEF_DBUF_EN
          valid_d = 1'b0;
`endif
        end
      end

      // A strobe mid-burst restarts at word 0; partial data is simply overwritten.
      LOAD: begin
        ack_d = 1'b1;
        if (isConfig) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
          if (cnt_q < CNT_WIDTH'(COEF_NUM)) begin
            wr_c.en = 1'b1;
          end else if (cnt_q == CNT_WIDTH'(IDX_SCALE)) begin
            shd_scal_d = Data_Config_In[CICC_SCALE_WIDTH-1:0];
          end else if (cnt_q == CNT_WIDTH'(IDX_SYM)) begin
            shd_sym_d = Data_Config_In[0];
            state_d   = SWAP;
          end
        end
      end

      SWAP: begin
        scal_d  = shd_scal_q;
        sym_d   = shd_sym_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
        ack_d   = 1'b0;
        cnt_d   = '0;
`ifdef CICC_COEF_DBUF_EN
        bank_sel_d = ~bank_sel_q;
`endif
        if (isConfig) begin
          state_d = LOAD;
`ifndef CICC_COEF_DBUF_EN
          valid_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  cicc_coef_ram u_ram (
    .clk       (CLK),
    .rst_n     (nRST),
    .wr_i      (wr_c),
    .rd_en_i   (addr_in_range(Coef_Rd_Addr)),
    .rd_addr_i (rd_addr_c),
    .rd_data_o (Coef_Rd_Data)
  );

  assign isConfigACK  = ack_q;
  assign isConfigDone = done_q;
  assign Coef_ScalVal = scal_q;
  assign isCoefSym    = sym_q;
  assign isCoefValid  = valid_q;

endmodule

// File: doc/cicc_coef_loader.md
# cicc_coef_loader

Downstream consumer of the CIC/CICC configuration distributor's CICC branch. It receives the CICC configuration burst: `isConfig` pulse, then 259 words of coefficients, scale value and symmetry flag. It writes the burst into a shadow coefficient bank and swaps that bank into service atomically, so the compensation FIR MAC never reads a half-loaded coefficient set. It answers the distributor with `isConfigACK`/`isConfigDone` and serves the FIR through a 1-cycle-latency read port.

## Interface
- CONFIG_WIDTH, 32, width of incoming config word
- CICC_COEFF_WIDTH, 24, coefficient width (taken from `Data_Config_In[23:0]`)
- CICC_SCALE_WIDTH, 16, scale value width (taken from `Data_Config_In[15:0]`)
- FILTER_ORDER, 256, FIR order; COEF_NUM = FILTER_ORDER+1 = 257
- CICC_CONFIG_DATA_NUM, 259, burst length = COEF_NUM + 2
- ADDR_WIDTH, 9, coefficient address width (must satisfy 2^ADDR_WIDTH ≥ COEF_NUM)

Ports:
- CLK  in  1  clock; all logic on rising edge
- nRST  in  1  asynchronous, active-low reset
- isConfig  in  1  start-of-burst strobe, one cycle
- Data_Config_In  in  CONFIG_WIDTH  burst word, one per cycle, no valid qualifier
- isConfigACK  out  1  high while a load is in progress
- isConfigDone  out  1  one-cycle pulse on the swap cycle
- Coef_Rd_Addr  in  ADDR_WIDTH  FIR read address
- Coef_Rd_Data  out  CICC_COEFF_WIDTH  registered coefficient from the active bank
- Coef_ScalVal  out  CICC_SCALE_WIDTH  active scale value
- isCoefSym  out  1  active symmetry flag (`Data_Config_In[0]` of the last word)
- isCoefValid  out  1  active bank holds a complete coefficient set

## Operation
- Burst word order:
  - words 0..256: coefficients for addresses 0..256
  - word 257: scale value
  - word 258: symmetry flag
- State machine:
  - IDLE: `isConfig`=1 → LOAD; `cnt` set to 0.
  - LOAD: each cycle, capture word `cnt`:
    - `cnt` < COEF_NUM → write the shadow bank at address `cnt`.
    - `cnt` = COEF_NUM → shadow scale register.
    - `cnt` = COEF_NUM+1 → shadow symmetry register, then go to SWAP.
    - Otherwise `cnt` increments.
  - SWAP: toggle `bank_sel`, copy shadow scale and symmetry to the active registers, set `isCoefValid`=1, pulse `isConfigDone`, clear `isConfigACK`, then go to IDLE.
- `isConfig`=1 during LOAD: restart the burst. `cnt` goes to 0, partial shadow data is discarded (later overwritten), `isConfigACK` stays 1, and no Done is issued for the aborted burst.
- `isConfig`=1 during SWAP: the swap completes, and the next cycle enters LOAD with `cnt`=0 (this is the distributor's re-config path).
- `Coef_Rd_Addr` ≥ COEF_NUM: `Coef_Rd_Data` = 0.
- Widths: coefficients truncate to the low CICC_COEFF_WIDTH bits, and the scale value to the low CICC_SCALE_WIDTH bits; no sign extension is performed here.
- Reset values:
  - `isConfigACK`=0, `isConfigDone`=0
  - `Coef_Rd_Data`=0, `Coef_ScalVal`=0, `isCoefSym`=0, `isCoefValid`=0
  - `bank_sel`=0, state IDLE, `cnt`=0
- RAM contents are not reset.
- Reset mid-load: the burst is lost and `isCoefValid` returns to 0.

## Timing
- E0 is the edge that samples `isConfig`=1. `isConfigACK`=1 after E0.
- Edges E1..E259 sample words 0..258.
- Edge E260 is the SWAP edge. After E260: `isConfigDone`=1 for one cycle, `isConfigACK`=0, and the new scale, symmetry and bank are active.
- Total: 260 cycles from the `isConfig` edge to Done.
- Read latency is 1 cycle: the address sampled at edge Ek gives data after Ek.
  - Reads sampled at or before E260 return the old bank.
  - Reads sampled at E261 or later return the new bank.
- Back-to-back bursts are supported with zero idle cycles.

## Configuration
- `CICC_COEF_DBUF_EN` defined:
  - Two banks (2×COEF_NUM words), ping-pong as described above.
  - `isCoefValid` stays 1 across reloads once the first load completes.
- Not defined:
  - Single bank, written in place; `bank_sel` is absent.
  - `isCoefValid` falls to 0 after E0 and rises after E260. The FIR must hold off while it is low.
  - Scale and symmetry still update at SWAP only.

## Structure
- Package `cicc_cfg_pkg` holds:
  - the width and count constants (CONFIG_WIDTH, CICC_COEFF_WIDTH, CICC_SCALE_WIDTH, COEF_NUM, CICC_CONFIG_DATA_NUM);
  - the state encoding IDLE/LOAD/SWAP;
  - the word-index constants IDX_SCALE=257 and IDX_SYM=258.
- Sub-module `cicc_coef_ram`:
  - simple dual-port RAM: one write port, one registered read port;
  - depth 2^(ADDR_WIDTH+1) with DBUF, 2^ADDR_WIDTH without.
- The bank select is the RAM's address MSB.

## Test plan
- Reset, then a burst with coefficients = address+1, scale 0x0123, sym 1:
  - Done occurs exactly 260 cycles after `isConfig`.
  - Reading address 0 gives 1 and address 256 gives 257.
  - `Coef_ScalVal`=0x0123, `isCoefSym`=1, `isCoefValid`=1.
- With DBUF, load set A (all 0x000AAA), then set B (all 0x000BBB) while reading address 5 every cycle:
  - reads return 0x000AAA through E260 of burst B and 0x000BBB from E261 on;
  - `isCoefValid` never drops.
- `isConfig` re-asserted at word 100:
  - no Done at 260 cycles after the first strobe;
  - Done at 260 cycles after the second strobe;
  - RAM holds only the second burst's data.
- `nRST` pulsed low at word 50 of a burst after a prior good load:
  - all outputs return to 0;
  - no Done occurs;
  - a fresh burst then loads correctly.
- `Coef_Rd_Addr`=300 gives `Coef_Rd_Data`=0.
- Two back-to-back bursts with `isConfig` in the SWAP cycle:
  - two Done pulses, 260 cycles apart;
  - `isConfigACK` is low for exactly one cycle between the bursts.
- Without DBUF: `isCoefValid` is 0 from after E0 until after E260.
